ibex_rf_wr_sched: RTL and testbench



---
 rtl/ibex_rf_wr_sched_pkg.sv | 17 +
 rtl/ibex_rf_wr_sched_if.sv | 31 +++
 rtl/ibex_rf_wr_sched.sv | 109 ++++++++++
 tb/tb_ibex_rf_wr_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wr_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package ibex_rf_wr_sched_pkg;

  typedef enum logic [1:0] {
    RfWrSchedStart,
    RfWrSchedInit,
    RfWrSchedRun
  } rf_wr_sched_state_e;

  // Write addresses are always carried at full RV32I width.
  localparam int unsigned RfAddrW = 5;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

endpackage

// File: rtl/ibex_rf_wr_sched_if.sv
// Writeback request/grant handshakes and the register-file write port.
interface ibex_rf_wr_sched_if
  import ibex_rf_wr_sched_pkg::*;
#(
  parameter int unsigned DataWidth = 32
);

  logic                 ex_req;
  logic [RfAddrW-1:0]   ex_waddr;
  logic [DataWidth-1:0] ex_wdata;
  logic                 ex_gnt;
  logic                 lsu_req;
  logic [RfAddrW-1:0]   lsu_waddr;
  logic [DataWidth-1:0] lsu_wdata;
  logic                 lsu_gnt;
  logic                 rf_we;
  logic [RfAddrW-1:0]   rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 init_done;

  modport master (
    output ex_req, ex_waddr, ex_wdata, lsu_req, lsu_waddr, lsu_wdata,
    input  ex_gnt, lsu_gnt, rf_we, rf_waddr, rf_wdata, init_done
  );

  modport slave (
    input  ex_req, ex_waddr, ex_wdata, lsu_req, lsu_waddr, lsu_wdata,
    output ex_gnt, lsu_gnt, rf_we, rf_waddr, rf_wdata, init_done
  );

endinterface

// File: rtl/ibex_rf_wr_sched.sv
// Owns the latch register file's single write port: clears the file after reset,
// then arbitrates EX and LSU writebacks with LSU priority and EX starvation relief.
module ibex_rf_wr_sched
  import ibex_rf_wr_sched_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   InitOnReset = 1'b1,
  parameter int unsigned          StarveLimit = 3
) (
  input  logic               clk_int,
  input  logic               rst_ni,
  ibex_rf_wr_sched_if.slave  bus
);

  localparam int unsigned AddrW    = rf_addr_width(RV32E);
  localparam int unsigned NumWords = 2 ** AddrW;
  localparam int unsigned StarveW  = $clog2(StarveLimit + 1);

  localparam logic [AddrW-1:0]   InitFirst = AddrW'(1);
  localparam logic [AddrW-1:0]   InitLast  = AddrW'(NumWords - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  rf_wr_sched_state_e   state_q, state_d;
  logic [AddrW-1:0]     init_cnt_q, init_cnt_d;
  logic [StarveW-1:0]   starve_cnt_q, starve_cnt_d;
  logic                 init_done_q;

  logic                 ex_gnt, lsu_gnt, ex_prio;
  logic                 we;
  logic [RfAddrW-1:0]   waddr;
  logic [DataWidth-1:0] wdata;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    starve_cnt_d = starve_cnt_q;
    ex_gnt       = 1'b0;
    lsu_gnt      = 1'b0;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    ex_prio      = (starve_cnt_q == StarveMax);

    unique case (state_q)
      RfWrSchedStart: begin
        init_cnt_d = InitFirst;
        state_d    = InitOnReset ? RfWrSchedInit : RfWrSchedRun;
      end

      // x0 is hardwired, so the sweep starts at 1 and stops on the last word.
      RfWrSchedInit: begin
        we    = 1'b1;
        waddr = RfAddrW'(init_cnt_q);
        wdata = WordZeroVal;
        if (init_cnt_q == InitLast) begin
          state_d = RfWrSchedRun;
        end else begin
          init_cnt_d = init_cnt_q + AddrW'(1);
        end
      end

      RfWrSchedRun: begin
        if (bus.ex_req && (!bus.lsu_req || ex_prio)) begin
          ex_gnt = 1'b1;
          waddr  = bus.ex_waddr;
          wdata  = bus.ex_wdata;
        end else if (bus.lsu_req) begin
          lsu_gnt = 1'b1;
          waddr   = bus.lsu_waddr;
          wdata   = bus.lsu_wdata;
        end
        // A write to x0 still retires the request but never reaches the file.
        we = (ex_gnt || lsu_gnt) && (waddr != '0);

        if (ex_gnt) begin
          starve_cnt_d = '0;
        end else if (bus.ex_req && (starve_cnt_q != StarveMax)) begin
          starve_cnt_d = starve_cnt_q + StarveW'(1);
        end
      end

      default: state_d = RfWrSchedStart;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RfWrSchedStart;
      init_cnt_q   <= InitFirst;
      starve_cnt_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      init_done_q  <= (state_d == RfWrSchedRun);
    end
  end

  assign bus.ex_gnt    = ex_gnt;
  assign bus.lsu_gnt   = lsu_gnt;
  assign bus.rf_we     = we;
  assign bus.rf_waddr  = waddr;
  assign bus.rf_wdata  = wdata;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_ibex_rf_wr_sched.sv
// Bench for ibex_rf_wr_sched: directed init/reset sequences, a vector table and
// randomized traffic checked against a wait-count arbitration model.
module tb_ibex_rf_wr_sched;
  import ibex_rf_wr_sched_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SL = 3;
  localparam int unsigned NW = 32;

  logic clk_int = 1'b0;
  logic rst_ni  = 1'b0;
  always #5 clk_int = ~clk_int;

  ibex_rf_wr_sched_if #(.DataWidth(DW)) bus ();

  ibex_rf_wr_sched #(
    .RV32E       (1'b0),
    .DataWidth   (DW),
    .WordZeroVal ('0),
    .InitOnReset (1'b1),
    .StarveLimit (SL)
  ) dut (
    .clk_int (clk_int),
    .rst_ni  (rst_ni),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic er, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lr, input logic [4:0] la, input logic [31:0] ld);
    bus.ex_req    = er;
    bus.ex_waddr  = ea;
    bus.ex_wdata  = ed;
    bus.lsu_req   = lr;
    bus.lsu_waddr = la;
    bus.lsu_wdata = ld;
  endtask

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic eg, input logic lg, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd, input logic done);
    chk({tag, ".ex_gnt"},    bus.ex_gnt,    eg);
    chk({tag, ".lsu_gnt"},   bus.lsu_gnt,   lg);
    chk({tag, ".rf_we"},     bus.rf_we,     we);
    chk({tag, ".rf_waddr"},  bus.rf_waddr,  wa);
    chk({tag, ".rf_wdata"},  bus.rf_wdata,  wd);
    chk({tag, ".init_done"}, bus.init_done, done);
  endtask

  // Called in the cycle reset is released: START, then the full sweep 1..NW-1.
  task automatic check_init(input string tag);
    @(negedge clk_int);
    expect_out({tag, ".start"}, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 1; i < NW; i++) begin
      tick();
      @(negedge clk_int);
      expect_out($sformatf("%s.w%0d", tag, i), 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, 1'b0);
    end
  endtask

  // Port-level properties that must hold on every cycle out of reset.
  always @(negedge clk_int) begin
    if (rst_ni) begin
      chk("inv_onehot", {63'd0, bus.ex_gnt & bus.lsu_gnt}, 64'd0);
      if (bus.rf_we) begin
        chk("inv_we_addr_nonzero", {63'd0, bus.rf_waddr != 5'd0}, 64'd1);
        chk("inv_we_source", {63'd0, bus.ex_gnt | bus.lsu_gnt | ~bus.init_done}, 64'd1);
      end
    end
  end

  typedef struct {
    logic        er;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        lr;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        eg;
    logic        lg;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [15];

  logic        er, lr, exp_eg, exp_lg, exp_we;
  logic [4:0]  ea, la, exp_wa;
  logic [31:0] ed, ld, exp_wd;
  int          ex_wait;

  initial begin
    //            ex req/addr/data         lsu req/addr/data          eg lg we  wa    wd
    tbl[0]  = '{1'b1, 5'd5,  32'hA,       1'b1, 5'd7,  32'hB,        1'b0, 1'b1, 1'b1, 5'd7,  32'hB};
    tbl[1]  = '{1'b1, 5'd5,  32'hA,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hA};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hDEADBEEF};
    tbl[4]  = '{1'b1, 5'd3,  32'hC,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  32'hC};
    tbl[5]  = '{1'b1, 5'd0,  32'h1234,    1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h1234};
    tbl[6]  = '{1'b1, 5'd9,  32'hD,       1'b1, 5'd10, 32'hE,        1'b0, 1'b1, 1'b1, 5'd10, 32'hE};
    tbl[7]  = '{1'b1, 5'd9,  32'hD,       1'b1, 5'd11, 32'hF,        1'b0, 1'b1, 1'b1, 5'd11, 32'hF};
    tbl[8]  = '{1'b1, 5'd9,  32'hD,       1'b1, 5'd12, 32'h10,       1'b0, 1'b1, 1'b1, 5'd12, 32'h10};
    tbl[9]  = '{1'b1, 5'd9,  32'hD,       1'b1, 5'd12, 32'h10,       1'b1, 1'b0, 1'b1, 5'd9,  32'hD};
    tbl[10] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd12, 32'h10,       1'b0, 1'b1, 1'b1, 5'd12, 32'h10};
    tbl[11] = '{1'b1, 5'd17, 32'h11,      1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd17, 32'h11};
    tbl[12] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[13] = '{1'b1, 5'd2,  32'h22,      1'b1, 5'd4,  32'h44,       1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    tbl[14] = '{1'b1, 5'd2,  32'h22,      1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd2,  32'h22};

    // Reset state, with an EX request already waiting through the whole init.
    drive(1'b1, 5'd6, 32'h600D, 1'b0, 5'd0, 32'd0);
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_int);
    @(negedge clk_int);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    tick();
    rst_ni = 1'b1;
    check_init("init1");
    tick();
    @(negedge clk_int);
    expect_out("run_first", 1'b1, 1'b0, 1'b1, 5'd6, 32'h600D, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk_int);
    expect_out("idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

    for (int v = 0; v < 15; v++) begin
      tick();
      drive(tbl[v].er, tbl[v].ea, tbl[v].ed, tbl[v].lr, tbl[v].la, tbl[v].ld);
      @(negedge clk_int);
      expect_out($sformatf("vec%0d", v), tbl[v].eg, tbl[v].lg, tbl[v].we, tbl[v].wa, tbl[v].wd, 1'b1);
    end

    // Random traffic; requesters hold until the model says they were granted.
    // ex_wait = cycles EX has been kept waiting since its last grant.
    ex_wait = 0;
    er = 1'b0; lr = 1'b0; ea = '0; la = '0; ed = '0; ld = '0;
    exp_eg = 1'b1; exp_lg = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!er || exp_eg) begin
        er = ($urandom_range(0, 99) < 65);
        ea = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ed = $urandom;
      end
      if (!lr || exp_lg) begin
        lr = ($urandom_range(0, 99) < 70);
        la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld = $urandom;
      end
      exp_eg = er && (!lr || ex_wait >= SL);
      exp_lg = lr && !exp_eg;
      exp_wa = exp_eg ? ea : (exp_lg ? la : 5'd0);
      exp_wd = exp_eg ? ed : (exp_lg ? ld : 32'd0);
      exp_we = (exp_eg || exp_lg) && (exp_wa != 5'd0);
      tick();
      drive(er, ea, ed, lr, la, ld);
      @(negedge clk_int);
      expect_out($sformatf("rand%0d", c), exp_eg, exp_lg, exp_we, exp_wa, exp_wd, 1'b1);
      if (exp_eg) ex_wait = 0;
      else if (er) ex_wait++;
    end

    // Reset in the middle of init, with both requesters pending.
    tick();
    drive(1'b1, 5'd21, 32'h2121, 1'b1, 5'd22, 32'h2222);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_int);
    expect_out("rst2.start", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      @(negedge clk_int);
      expect_out($sformatf("pre.w%0d", i), 1'b0, 1'b0, 1'b1, 5'(i), 32'd0, 1'b0);
    end
    tick();
    rst_ni = 1'b0;
    @(negedge clk_int);
    expect_out("midinit_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    @(negedge clk_int);
    expect_out("midinit_rst_hold", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    rst_ni = 1'b1;
    check_init("init2");
    tick();
    @(negedge clk_int);
    expect_out("rerun_lsu", 1'b0, 1'b1, 1'b1, 5'd22, 32'h2222, 1'b1);
    tick();
    drive(1'b1, 5'd21, 32'h2121, 1'b0, 5'd0, 32'd0);
    @(negedge clk_int);
    expect_out("rerun_ex", 1'b1, 1'b0, 1'b1, 5'd21, 32'h2121, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
